deserializador_fifo: RTL and testbench
======================================

Name: deserializador_fifo

Overview:
Parametrised successor to the single-word serial-to-parallel receiver. It assembles WIDTH-bit words from a bit-serial stream qualified by write_in, and buffers up to DEPTH completed words in an internal FIFO. Each word is presented on a data_ready/ack_in handshake, with one word consumed per ack_in rising edge. It sits between the serial link and the parallel consumer, and applies backpressure through status_out when the FIFO is full.

Parameters:
WIDTH, 8, word width in bits; legal values are 2 or more.
DEPTH, 4, FIFO depth in words; must be a power of 2, at least 2.
MSB_FIRST, 1, bit order: 1 means the first received bit ends up in data_out[WIDTH-1]; 0 means it ends up in data_out[0].

Ports:
clk_100KHz  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
data_in  input  1  serial data bit, sampled when write_in=1.
write_in  input  1  bit-valid strobe; one bit is accepted per cycle when accepted.
ack_in  input  1  consumer acknowledge; a 0->1 transition pops the head word.
flush  input  1  synchronous clear of the shift register and FIFO.
status_out  output  1  1 when the FIFO is full; write_in is ignored while high.
data_out  output  WIDTH  head word of the FIFO; all zeros when the FIFO is empty.
data_ready  output  1  1 when the FIFO is non-empty.
fill_level  output  $clog2(DEPTH+1)  number of words currently stored.
parity_err  output  1  one-cycle error pulse (optional feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset (reset=0, asynchronous): shift register, bit counter, read/write pointers, ack edge register, fill_level, parity_err all 0. Resulting outputs: data_out=0, data_ready=0, status_out=0. Assertion mid-word discards the partial word and all stored words.
- Shift, MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], data_in}.
- Shift, MSB_FIRST=0: sreg <= {data_in, sreg[WIDTH-1:1]}.
- A bit is accepted only when write_in=1 and status_out=0. Each accepted bit increments the bit counter (0..WIDTH-1).
- Word completion: the WIDTH-th accepted bit pushes {assembled word including that bit} into the FIFO on the same edge. The bit counter returns to 0.
- Latency: data_ready and data_out are valid in the cycle after the edge that sampled the last bit.
- While status_out=1, write_in bits are dropped: no shift, no count. The sender must stall.
- status_out, data_ready and data_out are combinational from registered state: status_out = (fill_level==DEPTH); data_ready = (fill_level!=0).
- Pop: ack_rise = ack_in & ~ack_q, where ack_q is ack_in registered.
  - If ack_rise=1 and the FIFO is non-empty, the read pointer advances and fill_level decrements.
  - ack_rise while empty is ignored.
  - ack_in held high pops exactly one word. A new pop requires ack_in to return to 0 first.
- Simultaneous push and pop (FIFO neither empty nor full): both occur and fill_level is unchanged.
- When full, status_out blocks the push even if a pop occurs the same cycle. The bit is dropped, and status_out falls the following cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by fill_level.
- flush=1: clears the bit counter, shift register, pointers and fill_level on the next edge. It has priority over push and pop in the same cycle. ack_q keeps tracking ack_in.
- Word framing relies solely on the bit counter; there is no resynchronisation other than flush or reset.

Optional Feature:
Macro DESER_PARITY_EN.
- Defined: each frame is WIDTH data bits followed by one even-parity bit, and the counter runs 0..WIDTH.
  - If XOR(data bits, parity bit)=0, the word is pushed on the parity-bit edge.
  - Otherwise the word is discarded, nothing is pushed, and parity_err=1 for exactly one cycle after that edge.
  - Backpressure gating of data and parity bits is unchanged.
- Undefined: frames are WIDTH bits, parity_err is constant 0, and there is no parity logic.

Test Plan:
- Reset then MSB_FIRST=1, WIDTH=8: send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> data_ready=1 one cycle after the 8th bit, data_out=8'hA5, fill_level=1; ack 0->1 -> data_ready=0, data_out=0.
- MSB_FIRST=0, same bit sequence -> data_out=8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> data_out=8'h03.
- DEPTH=4: push 5 words 8'h11,22,33,44,55 without ack -> status_out=1 after the 4th word, 5th word's bits dropped, fill_level=4; four ack pulses -> heads 11,22,33,44 in order, then data_ready=0.
- Hold ack_in=1 for 10 cycles with 3 words stored -> exactly one pop (fill_level 3->2). Simultaneous last-bit push and ack rise with fill_level=2 -> fill_level stays 2.
- Assert reset=0 after 5 of 8 bits with 2 words stored -> all outputs 0 immediately. After release, 8 new bits form a clean word (no residue from the partial word).
- DESER_PARITY_EN: frame 8'hA5 + parity 0 -> pushed; frame 8'hA5 + parity 1 -> not pushed, parity_err high for one cycle, fill_level unchanged.

Source files
------------

// File: rtl/deserializador_fifo.sv
// Serial-to-parallel receiver with a DEPTH-word FIFO and ack-edge popping.
// Optional macro DESER_PARITY_EN appends an even-parity bit to every frame.
module deserializador_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                           clk_100KHz,
  input  logic                           reset,
  input  logic                           data_in,
  input  logic                           write_in,
  input  logic                           ack_in,
  input  logic                           flush,
  output logic                           status_out,
  output logic [WIDTH-1:0]               data_out,
  output logic                           data_ready,
  output logic [$clog2(DEPTH+1)-1:0]     fill_level,
  output logic                           parity_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
`ifdef DESER_PARITY_EN
  localparam int unsigned LAST_CNT = WIDTH;
`else
  localparam int unsigned LAST_CNT = WIDTH - 1;
`endif
  localparam int unsigned CNT_W = $clog2(LAST_CNT + 1);

  logic [WIDTH-1:0]  sreg_q, sreg_d, shifted, word;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              ack_q, ack_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic              full, accept, push, pop;
`ifdef DESER_PARITY_EN
  logic              err_q, err_d;
`endif

  assign full    = (fill_q == FILL_W'(DEPTH));
  assign accept  = write_in & ~full;
  assign pop     = ack_in & ~ack_q & (fill_q != '0);
  assign shifted = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], data_in}
                                    : {data_in, sreg_q[WIDTH-1:1]};

  // Frame assembly, FIFO push/pop and flush; flush overrides everything.
  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ack_d    = ack_in;
    mem_d    = mem_q;
    push     = 1'b0;
    word     = shifted;
`ifdef DESER_PARITY_EN
    err_d    = 1'b0;
`endif

    if (accept) begin
      if (cnt_q == CNT_W'(LAST_CNT)) begin
        cnt_d = '0;
`ifdef DESER_PARITY_EN
        // Parity bit: data already complete in sreg_q, no shift.
        word = sreg_q;
        if (^{sreg_q, data_in}) err_d = 1'b1;
        else                    push  = 1'b1;
`else
        sreg_d = shifted;
        push   = 1'b1;
`endif
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        sreg_d = shifted;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (pop && !push) fill_d = fill_q - FILL_W'(1);

    if (flush) begin
      sreg_d   = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      mem_d    = mem_q;
`ifdef DESER_PARITY_EN
      err_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ack_q    <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ack_q    <= ack_d;
      mem_q    <= mem_d;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign parity_err = err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign status_out = full;
  assign data_ready = (fill_q != '0);
  assign data_out   = data_ready ? mem_q[rd_ptr_q] : '0;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_deserializador_fifo.sv
// Directed bench for deserializador_fifo: vector table plus multi-cycle corner sequences.
module tb_deserializador_fifo;

  logic       clk_100KHz = 1'b0;
  logic       reset, data_in, write_in, ack_in, flush;
  logic       status_out, data_ready, parity_err;
  logic [7:0] data_out;
  logic [2:0] fill_level;
  logic       l_status, l_ready, l_perr;
  logic [7:0] l_data;
  logic [2:0] l_fill;

  int errors = 0;
  int checks = 0;

  deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .flush(flush), .status_out(status_out), .data_out(data_out),
    .data_ready(data_ready), .fill_level(fill_level), .parity_err(parity_err));

  deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .flush(flush), .status_out(l_status), .data_out(l_data),
    .data_ready(l_ready), .fill_level(l_fill), .parity_err(l_perr));

  always #5 clk_100KHz = ~clk_100KHz;

  typedef struct {
    bit         is_ack;
    logic [7:0] word;
    logic [7:0] exp_data;
    int         exp_fill;
    bit         exp_ready;
    bit         exp_status;
  } vec_t;

  vec_t vec [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100KHz);
    #1;
  endtask

  // Sends the top n bits of f (MSB first); optionally raises ack_in with the last bit.
  task automatic send_frame(input logic [8:0] f, input int n, input bit ack_last);
    for (int i = 0; i < n; i++) begin
      data_in  = f[8-i];
      write_in = 1'b1;
      if (ack_last && i == n - 1) ack_in = 1'b1;
      tick();
    end
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit ack_last);
`ifdef DESER_PARITY_EN
    send_frame({w, ^w}, 9, ack_last);
`else
    send_frame({w, 1'b0}, 8, ack_last);
`endif
  endtask

  task automatic ack_pulse();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    tick();
  endtask

  task automatic check_head(input string name, input logic [7:0] d, input int f);
    check({name, ".data"}, 32'(data_out), 32'(d));
    check({name, ".fill"}, 32'(fill_level), 32'(f));
  endtask

  initial begin
    reset = 1'b0; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0; flush = 1'b0;

    vec[0]  = '{1'b0, 8'hA5, 8'hA5, 1, 1'b1, 1'b0};
    vec[1]  = '{1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 8'h11, 8'h11, 1, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 8'h22, 8'h11, 2, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 8'h33, 8'h11, 3, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 8'h44, 8'h11, 4, 1'b1, 1'b1};
    vec[6]  = '{1'b0, 8'h55, 8'h11, 4, 1'b1, 1'b1};
    vec[7]  = '{1'b1, 8'h00, 8'h22, 3, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 8'h00, 8'h33, 2, 1'b1, 1'b0};
    vec[9]  = '{1'b1, 8'h00, 8'h44, 1, 1'b1, 1'b0};
    vec[10] = '{1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b0};

    tick();
    tick();
    check("rst.data", 32'(data_out), 32'h0);
    check("rst.ready", 32'(data_ready), 32'h0);
    check("rst.status", 32'(status_out), 32'h0);
    check("rst.fill", 32'(fill_level), 32'h0);
    check("rst.perr", 32'(parity_err), 32'h0);
    reset = 1'b1;
    tick();

    // Bit order: both instances see the same stream.
    send_word(8'hA5, 1'b0);
    check("order.a5.msb", 32'(data_out), 32'hA5);
    check("order.a5.lsb", 32'(l_data), 32'hA5);
    send_word(8'hC0, 1'b0);
    check("order.fill", 32'(fill_level), 32'h2);
    ack_pulse();
    check("order.c0.msb", 32'(data_out), 32'hC0);
    check("order.03.lsb", 32'(l_data), 32'h03);
    ack_pulse();
    check("order.empty", 32'(l_ready), 32'h0);

    for (int i = 0; i < 11; i++) begin
      if (vec[i].is_ack) ack_pulse();
      else               send_word(vec[i].word, 1'b0);
      check($sformatf("vec%0d.data", i), 32'(data_out), 32'(vec[i].exp_data));
      check($sformatf("vec%0d.fill", i), 32'(fill_level), 32'(vec[i].exp_fill));
      check($sformatf("vec%0d.ready", i), 32'(data_ready), 32'(vec[i].exp_ready));
      check($sformatf("vec%0d.status", i), 32'(status_out), 32'(vec[i].exp_status));
    end

    // Ack while empty is ignored.
    ack_pulse();
    check("empty_ack.fill", 32'(fill_level), 32'h0);
    send_word(8'h01, 1'b0);
    check_head("empty_ack.push", 8'h01, 1);

    // Held ack pops exactly one word.
    send_word(8'h02, 1'b0);
    send_word(8'h03, 1'b0);
    ack_in = 1'b1;
    repeat (10) tick();
    check_head("hold_ack", 8'h02, 2);
    ack_in = 1'b0;
    tick();

    // Push and pop on the same edge keep the level.
    send_word(8'h04, 1'b1);
    check_head("push_pop", 8'h03, 2);
    ack_in = 1'b0;
    tick();
    check_head("push_pop.after", 8'h03, 2);

    // Asynchronous reset in the middle of a word.
    send_frame(9'h1FF, 5, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst.data", 32'(data_out), 32'h0);
    check("mid_rst.ready", 32'(data_ready), 32'h0);
    check("mid_rst.fill", 32'(fill_level), 32'h0);
    check("mid_rst.status", 32'(status_out), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    send_word(8'h5A, 1'b0);
    check_head("mid_rst.clean", 8'h5A, 1);

    // Full FIFO: a bit arriving with an ack rise is still dropped.
    send_word(8'h61, 1'b0);
    send_word(8'h62, 1'b0);
    send_word(8'h63, 1'b0);
    check("full.status", 32'(status_out), 32'h1);
    data_in = 1'b1; write_in = 1'b1; ack_in = 1'b1;
    tick();
    write_in = 1'b0; ack_in = 1'b0; data_in = 1'b0;
    check_head("full.pop", 8'h61, 3);
    check("full.status_fall", 32'(status_out), 32'h0);
    send_word(8'h77, 1'b0);
    check("full.again", 32'(status_out), 32'h1);
    ack_pulse();
    check_head("drain1", 8'h62, 3);
    ack_pulse();
    check_head("drain2", 8'h63, 2);
    ack_pulse();
    check_head("drain3", 8'h77, 1);
    ack_pulse();
    check_head("drain4", 8'h00, 0);

    // Flush clears stored words and a partial word.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_frame(9'h1FF, 3, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_head("flush", 8'h00, 0);
    send_word(8'hA5, 1'b0);
    check_head("flush.clean", 8'hA5, 1);

`ifdef DESER_PARITY_EN
    send_frame({8'hA5, 1'b0}, 9, 1'b0);
    check("par_ok.fill", 32'(fill_level), 32'h2);
    check("par_ok.err", 32'(parity_err), 32'h0);
    send_frame({8'hA5, 1'b1}, 9, 1'b0);
    check("par_bad.fill", 32'(fill_level), 32'h2);
    check("par_bad.err", 32'(parity_err), 32'h1);
    tick();
    check("par_bad.err_clr", 32'(parity_err), 32'h0);
`else
    check("no_par.err", 32'(parity_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
